pll_lock_seq: RTL and testbench

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

---
 rtl/pll_lock_seq.sv | 179 +++++++++++++++++
 tb/tb_pll_lock_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_seq.sv
// PLL reset/lock-acquisition sequencer with lock filtering, retry/fault handling and
// staggered per-channel reset release. Define PLL_LOL_COUNT_EN to build the loss-of-lock counter.
module pll_lock_seq #(
    parameter int NUM_CH       = 2,
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_FILT    = 1024,
    parameter int CH_GAP       = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clkin,
    input  logic              reset_n,
    input  logic              lock_in,
    input  logic              relock_req,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              ready,
    output logic              fault,
    output logic [3:0]        retry_cnt,
    output logic [7:0]        lol_cnt
);

    localparam int REL_LAST = (NUM_CH - 1) * CH_GAP;
    localparam int PW = (RST_PULSE > 1)    ? $clog2(RST_PULSE)    : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int FW = (LOCK_FILT > 1)    ? $clog2(LOCK_FILT)    : 1;
    localparam int RW = (REL_LAST > 0)     ? $clog2(REL_LAST + 1) : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILT - 1);
    localparam logic [RW-1:0] REL_END    = RW'(REL_LAST);
    localparam logic [3:0]    RETRY_LAST = 4'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic          lock_meta_q, lock_s_q;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [RW-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]    retry_q, retry_d;

    // State register, lock synchroniser and per-state counters
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_PLL_RST;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pulse_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            filt_cnt_q  <= '0;
            rel_cnt_q   <= '0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= lock_in;
            lock_s_q    <= lock_meta_q;
            pulse_cnt_q <= pulse_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            retry_q     <= retry_d;
        end
    end

    // Counters default to zero so every state is entered with a fresh count
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = '0;
        tmo_cnt_d   = '0;
        filt_cnt_d  = '0;
        rel_cnt_d   = '0;
        retry_d     = retry_q;
        if (relock_req) begin
            state_d = S_PLL_RST;
            retry_d = '0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        state_d = S_WAIT_LOCK;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_FILTER;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_q == RETRY_LAST) ? S_FAULT : S_PLL_RST;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                S_FILTER: begin
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                    end else if (filt_cnt_q == FILT_LAST) begin
                        state_d = S_RELEASE;
                    end else begin
                        filt_cnt_d = filt_cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!lock_s_q) begin
                        state_d = S_PLL_RST;
                        retry_d = '0;
                    end else if (rel_cnt_q == REL_END) begin
                        state_d = S_RUN;
                    end else begin
                        rel_cnt_d = rel_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        state_d = S_PLL_RST;
                        retry_d = '0;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_PLL_RST;
                end
            endcase
        end
    end

    // Outputs decode straight from flops so an async reset drops them without a clock edge
    always_comb begin
        pll_reset = (state_q == S_PLL_RST) || (state_q == S_FAULT);
        ready     = (state_q == S_RUN);
        fault     = (state_q == S_FAULT);
        retry_cnt = retry_q;
        ch_rst_n  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rst_n[i] = (state_q == S_RUN) ||
                          ((state_q == S_RELEASE) && (rel_cnt_q >= RW'(i * CH_GAP)));
        end
    end

`ifdef PLL_LOL_COUNT_EN
    logic       lol_event;
    logic [7:0] lol_q, lol_d;

    // A loss of lock while channels are out of reset counts even when relock_req wins
    always_comb begin
        lol_event = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !lock_s_q;
        lol_d     = lol_q;
        if (lol_event && (lol_q != 8'hFF)) begin
            lol_d = lol_q + 1'b1;
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            lol_q <= '0;
        end else begin
            lol_q <= lol_d;
        end
    end

    assign lol_cnt = lol_q;
`else
    assign lol_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq: randomized lock/relock stimulus against a
// time-in-phase reference model of the sequencer.
`timescale 1ns/1ps
module tb_pll_lock_seq;

    localparam int NUM_CH       = 4;
    localparam int RST_PULSE    = 4;
    localparam int LOCK_TIMEOUT = 64;
    localparam int LOCK_FILT    = 16;
    localparam int CH_GAP       = 2;
    localparam int MAX_RETRY    = 2;

`ifdef PLL_LOL_COUNT_EN
    localparam bit LOL_EN = 1'b1;
`else
    localparam bit LOL_EN = 1'b0;
`endif

    localparam int M_RST = 0, M_WAIT = 1, M_FILT = 2, M_REL = 3, M_RUN = 4, M_FAULT = 5;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              lock_in    = 1'b0;
    logic              relock_req = 1'b0;
    logic              pll_reset;
    logic [NUM_CH-1:0] ch_rst_n;
    logic              ready;
    logic              fault;
    logic [3:0]        retry_cnt;
    logic [7:0]        lol_cnt;
    logic [18:0]       dut_vec;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_mode;
    int m_t;
    int m_retry;
    int m_lol;
    bit lq[$];

    always #5 clk = ~clk;

    pll_lock_seq #(
        .NUM_CH(NUM_CH), .RST_PULSE(RST_PULSE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_FILT(LOCK_FILT), .CH_GAP(CH_GAP), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clkin(clk), .reset_n(reset_n), .lock_in(lock_in), .relock_req(relock_req),
        .pll_reset(pll_reset), .ch_rst_n(ch_rst_n), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .lol_cnt(lol_cnt)
    );

    assign dut_vec = {pll_reset, fault, ready, ch_rst_n, retry_cnt, lol_cnt};

    task automatic model_reset();
        lq      = {1'b0, 1'b0};
        m_mode  = M_RST;
        m_t     = 0;
        m_retry = 0;
        m_lol   = 0;
    endtask

    task automatic enter(input int mode);
        m_mode = mode;
        m_t    = 0;
    endtask

    // Reference: lock is seen two edges late; m_t counts edges spent in the current phase
    task automatic model_step(input bit lin, input bit rq);
        bit ls;
        ls = lq.pop_front();
        lq.push_back(lin);
        if ((m_mode == M_REL || m_mode == M_RUN) && !ls && LOL_EN && m_lol < 255) m_lol++;
        if (rq) begin
            m_retry = 0;
            enter(M_RST);
        end else begin
            case (m_mode)
                M_RST:  if (m_t + 1 == RST_PULSE) enter(M_WAIT); else m_t++;
                M_WAIT: begin
                    if (ls) enter(M_FILT);
                    else if (m_t + 1 == LOCK_TIMEOUT) begin
                        m_retry++;
                        enter((m_retry == MAX_RETRY) ? M_FAULT : M_RST);
                    end else m_t++;
                end
                M_FILT: if (!ls) enter(M_WAIT); else if (m_t + 1 == LOCK_FILT) enter(M_REL); else m_t++;
                M_REL: begin
                    if (!ls) begin m_retry = 0; enter(M_RST); end
                    else if (m_t == (NUM_CH - 1) * CH_GAP) enter(M_RUN);
                    else m_t++;
                end
                M_RUN: if (!ls) begin m_retry = 0; enter(M_RST); end
                default: ;
            endcase
        end
    endtask

    function automatic logic [18:0] exp_vec();
        logic [NUM_CH-1:0] ch;
        ch = '0;
        for (int i = 0; i < NUM_CH; i++)
            ch[i] = (m_mode == M_RUN) || (m_mode == M_REL && m_t >= i * CH_GAP);
        return {(m_mode == M_RST || m_mode == M_FAULT), (m_mode == M_FAULT), (m_mode == M_RUN),
                ch, 4'(m_retry), 8'(m_lol)};
    endfunction

    // Attempt count on entering FAULT is not pinned down, so it is left out of the compare there
    function automatic logic [18:0] exp_mask();
        return (m_mode == M_FAULT) ? ~19'h00F00 : {19{1'b1}};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step(lock_in, relock_req);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; lock_in = 1'b0; relock_req = 1'b0;
        #3;
        model_reset();
        checks++;
        if (dut_vec !== 19'h40000) begin
            errors++;
            $display("[TB] FAIL reset_state got=%h exp=%h", dut_vec, 19'h40000);
        end
        tick();
        checks++;
        if (dut_vec !== 19'h40000) begin
            errors++;
            $display("[TB] FAIL reset_held got=%h exp=%h", dut_vec, 19'h40000);
        end
        #2 reset_n = 1'b1;
    endtask

    task automatic test_lock_sequence();
        for (int i = 0; i < 60; i++) begin
            if (i == 10) lock_in = 1'b1;
            tick();
            checks++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                errors++;
                $display("[TB] FAIL lock_seq cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
        checks++;
        if (ready !== 1'b1 || ch_rst_n !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL lock_seq_run got ready=%b ch=%b exp ready=1 ch=1111", ready, ch_rst_n);
        end
    endtask

    task automatic test_filter_glitch();
        int n = 0;
        int glitch_at;
        glitch_at = $urandom_range(8, 12);
        lock_in = 1'b1; relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        while (!(m_mode == M_FILT && m_t == glitch_at) && n < 200) begin
            tick(); n++;
            checks++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                errors++;
                $display("[TB] FAIL filt_pre cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL filt_reach got=timeout exp=FILTER count %0d", glitch_at);
        end
        lock_in = 1'b0;
        tick();
        lock_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                errors++;
                $display("[TB] FAIL filt_glitch cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_timeout_fault();
        lock_in = 1'b0; relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        for (int i = 0; i < 2 * (RST_PULSE + LOCK_TIMEOUT) + 12; i++) begin
            tick();
            checks++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                errors++;
                $display("[TB] FAIL timeout cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
        checks++;
        if (fault !== 1'b1 || pll_reset !== 1'b1 || ch_rst_n !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL fault_state got fault=%b pll=%b ch=%b exp 1 1 0000", fault, pll_reset, ch_rst_n);
        end
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++;
        if (fault !== 1'b0 || pll_reset !== 1'b1 || retry_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL fault_relock got fault=%b pll=%b retry=%0d exp 0 1 0", fault, pll_reset, retry_cnt);
        end
    endtask

    task automatic test_lock_loss_run();
        int n = 0;
        int lol_before;
        lock_in = 1'b1;
        while (m_mode != M_RUN && n < 200) begin
            tick(); n++;
            checks++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                errors++;
                $display("[TB] FAIL loss_pre cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
        lol_before = m_lol;
        lock_in = 1'b0;
        tick();
        lock_in = 1'b1;
        tick(); tick();
        checks++;
        if (ready !== 1'b0 || ch_rst_n !== 4'b0000 || pll_reset !== 1'b1 ||
            lol_cnt !== (LOL_EN ? 8'(lol_before + 1) : 8'd0)) begin
            errors++;
            $display("[TB] FAIL loss_run got ready=%b ch=%b pll=%b lol=%0d exp 0 0000 1 %0d",
                     ready, ch_rst_n, pll_reset, lol_cnt, LOL_EN ? lol_before + 1 : 0);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                errors++;
                $display("[TB] FAIL loss_pulse cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        lock_in = 1'b1; relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        while (!(m_mode == M_REL && m_t == CH_GAP) && n < 200) begin
            tick(); n++;
        end
        checks++;
        if (ch_rst_n !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL async_pre got ch=%b exp ch=0011", ch_rst_n);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ch_rst_n !== 4'b0000 || pll_reset !== 1'b1 || ready !== 1'b0 || lol_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got ch=%b pll=%b ready=%b lol=%0d exp 0000 1 0 0",
                     ch_rst_n, pll_reset, ready, lol_cnt);
        end
        model_reset();
        #1 reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                errors++;
                $display("[TB] FAIL async_restart cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_lol_saturation();
        for (int k = 0; k < 260; k++) begin
            int n = 0;
            lock_in = 1'b1;
            while (m_mode != M_RUN && n < 200) begin
                tick(); n++;
                checks++;
                if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                    errors++;
                    $display("[TB] FAIL lol_seq cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
                end
            end
            if (n >= 200) begin
                checks++; errors++;
                $display("[TB] FAIL lol_reach got=timeout exp=RUN");
            end
            repeat ($urandom_range(0, 3)) tick();
            lock_in = 1'b0;
            tick();
        end
        lock_in = 1'b1;
        repeat (3) tick();
        checks++;
        if (lol_cnt !== (LOL_EN ? 8'd255 : 8'd0)) begin
            errors++;
            $display("[TB] FAIL lol_sat got=%0d exp=%0d", lol_cnt, LOL_EN ? 255 : 0);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                lock_in = ($urandom_range(0, 3) != 0);
                hold    = $urandom_range(1, 40);
            end
            hold--;
            relock_req = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
        relock_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_filter_glitch();
        test_timeout_fault();
        test_lock_loss_run();
        test_async_reset();
        test_lol_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
